m_tie_strap: RTL

- Parametrised successor of the fixed tie-off cells: drives a WIDTH-bit constant vector into the design.
- The vector is reset to a compile-time value, then replaced by board strap pins once they have settled.
- Software may override the vector until it is locked; after that it cannot change until reset.
- Sits next to the std_cells tie wrappers and feeds mode/config pins of IPs that previously used hard ties.

---
 rtl/m_tie_strap.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/m_tie_strap.sv
// Strap-loaded tie vector: synchronise/debounce board straps, allow software
// override until locked. Optional parity guard enabled by M_TIE_STRAP_PARITY_EN.
module m_tie_strap #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b1}},
    parameter int               SYNC_STAGES = 2,
    parameter int               SETTLE_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] strap_i,
    input  logic             ovr_valid_i,
    input  logic [WIDTH-1:0] ovr_data_i,
    output logic             ovr_ready_o,
    input  logic             lock_i,
    output logic [WIDTH-1:0] val_o,
    output logic             val_valid_o,
    output logic             locked_o,
    output logic             par_err_o
);

    generate
        if (SYNC_STAGES < 2 || SETTLE_CYC < 1) begin : g_bad_cfg
            $fatal(1, "m_tie_strap: SYNC_STAGES must be >= 2 and SETTLE_CYC >= 1");
        end
    endgenerate

    localparam int                CNT_W      = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic [WIDTH-1:0]       strap_s;
    logic                   samp_ok;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             val_valid_q, val_valid_d;
    logic             ovr_ready_q, ovr_ready_d;
    logic             locked_q, locked_d;
    logic             lock_pend_q, lock_pend_d;

    // fill_q marks when the synchroniser output holds a real strap sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            sync_q[0] <= strap_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign strap_s = sync_q[SYNC_STAGES-1];
    assign samp_ok = fill_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SETTLE;
            val_q       <= RST_VAL;
            prev_q      <= '0;
            cnt_q       <= '0;
            val_valid_q <= 1'b0;
            ovr_ready_q <= 1'b0;
            locked_q    <= 1'b0;
            lock_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            val_valid_q <= val_valid_d;
            ovr_ready_q <= ovr_ready_d;
            locked_q    <= locked_d;
            lock_pend_q <= lock_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        val_valid_d = val_valid_q;
        locked_d    = locked_q;
        lock_pend_d = lock_pend_q;

        case (state_q)
            ST_SETTLE: begin
                if (lock_i) begin
                    lock_pend_d = 1'b1;
                end
                if (samp_ok) begin
                    // cnt_q == 0 means no previous sample exists yet
                    prev_d = strap_s;
                    if (cnt_q != '0 && strap_s == prev_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                    if (cnt_d == SETTLE_MAX) begin
                        val_d       = strap_s;
                        val_valid_d = 1'b1;
                        if (lock_pend_q || lock_i) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d = ST_ACTIVE;
                        end
                    end
                end
            end
            ST_ACTIVE: begin
                if (ovr_valid_i && ovr_ready_q) begin
                    val_d = ovr_data_i;
                end
                if (lock_i) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase

        ovr_ready_d = (state_d == ST_ACTIVE);
    end

    assign val_o       = val_q;
    assign val_valid_o = val_valid_q;
    assign ovr_ready_o = ovr_ready_q;
    assign locked_o    = locked_q;

`ifdef M_TIE_STRAP_PARITY_EN
    logic par_q;
    logic par_err_q;

    // Parity follows only genuine loads; an upset in val_q leaves val_d == val_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= ^RST_VAL;
            par_err_q <= 1'b0;
        end else begin
            if (val_d != val_q) begin
                par_q <= ^val_d;
            end
            if ((^val_q) != par_q) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

endmodule
